instr_fetch_stage: RTL

- Fetch stage directly upstream of decode. It owns the 64-bit PC and issues requests to instruction memory under a valid/ready handshake.
- Accepts in-order responses of variable latency and buffers them with their PC in a small FIFO.
- Presents one instruction at a time to decode and the immediate generator (32-bit instruction plus PC), under valid/ready.
- A redirect from execute (branch taken) kills in-flight and buffered instructions.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and buffer entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned      XLEN      = 64;
  localparam int unsigned      ILEN      = 32;
  localparam logic [XLEN-1:0]  PC_STEP   = 64'd4;
  localparam logic [ILEN-1:0]  INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type          T     = fetch_entry_t,
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  T                 mem_q [DEPTH];

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop frees the slot, so a push into a full buffer is legal in the same cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC ownership, credit-limited imem requests, response buffer, redirect kill.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign flag that halts fetching.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 64'h0,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instruc,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [OW-1:0]   outstanding;
  logic [FW-1:0]   fifo_count;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [SW-1:0]   credit_used;
  fetch_entry_t    fifo_head, resp_entry;
  logic            accept, resp_ok, resp_push, fetch_stall;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign fetch_misalign  = misalign_q;
  assign fetch_stall     = misalign_q;
  assign redirect_target = redirect_pc;
`else
  assign fetch_stall     = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

  // The PC queue occupancy is the outstanding-request count.
  fetch_fifo #(
    .T     (logic [XLEN-1:0]),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pc_q),
    .pop       (resp_ok),
    .head      (resp_pc),
    .count     (outstanding)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (resp_push),
    .push_data (resp_entry),
    .pop       (id_valid && id_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    credit_used    = SW'(outstanding) - SW'(drop_cnt_q) + SW'(fifo_count);
    imem_req_valid = reset && !redirect_valid && !fetch_stall
                     && (outstanding < OW'(MAX_OUTSTANDING))
                     && (credit_used < SW'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    resp_ok        = imem_resp_valid && (outstanding != '0);
    resp_push      = resp_ok && !redirect_valid && (drop_cnt_q == '0);
    resp_entry     = '{instr: imem_resp_data, pc: resp_pc};

    id_valid   = (fifo_count != '0);
    id_instruc = id_valid ? fifo_head.instr : INSTR_NOP;
    id_pc      = id_valid ? fifo_head.pc : '0;

    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_target;
      drop_cnt_d = outstanding + OW'(accept) - OW'(resp_ok);
    end else begin
      if (accept) pc_d = pc_q + PC_STEP;
      if (resp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
